// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC/history-indexed 2-bit counters with a registered prediction.
// Optional macro PHT_BYPASS_EN forwards a same-cycle update into the prediction for a matching index.
module gshare_pht #(
    parameter int IDX_WIDTH = 4,
    parameter int PC_LSB    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_req,
    input  logic [31:0]          lookup_pc,
    input  logic [IDX_WIDTH-1:0] bhr_in,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [IDX_WIDTH-1:0] pred_idx,
    input  logic                 upd_valid,
    input  logic [IDX_WIDTH-1:0] upd_idx,
    input  logic                 upd_taken,
    output logic                 bhr_load,
    output logic                 bhr_branch_val,
    output logic                 ready
);

    localparam int ENTRIES = 1 << IDX_WIDTH;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] init_ptr_q, init_ptr_d;
    logic [1:0]           ctr_q [ENTRIES];

    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [IDX_WIDTH-1:0] pred_idx_q, pred_idx_d;

    logic [IDX_WIDTH-1:0] lookup_idx;
    logic [1:0]           lookup_ctr;
    logic [1:0]           upd_ctr_next;
    logic                 upd_commit;
    logic                 wr_en;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic [1:0]           wr_data;
    logic                 unused_pc;

    assign unused_pc  = ^{lookup_pc[31:PC_LSB+IDX_WIDTH], lookup_pc[PC_LSB-1:0]};
    assign lookup_idx = lookup_pc[PC_LSB+IDX_WIDTH-1:PC_LSB] ^ bhr_in;
    assign upd_commit = upd_valid && (state_q == READY);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == INIT) begin
            init_ptr_d = init_ptr_q + IDX_WIDTH'(1);
            if (init_ptr_q == IDX_WIDTH'(ENTRIES - 1)) state_d = READY;
        end
    end

    // Output logic; history drive is forced low while reset is held.
    always_comb begin
        ready          = (state_q == READY);
        bhr_load       = upd_valid & ~rst;
        bhr_branch_val = upd_taken & ~rst;
    end

    always_comb begin
        upd_ctr_next = ctr_q[upd_idx];
        if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) upd_ctr_next = ctr_q[upd_idx] + 2'd1;
        end else begin
            if (ctr_q[upd_idx] != 2'b00) upd_ctr_next = ctr_q[upd_idx] - 2'd1;
        end
    end

    // The init sweep owns the write port; updates arriving then are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_data = upd_ctr_next;
        if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_ptr_q;
            wr_data = 2'b01;
        end else if (upd_commit) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the counter array has no reset; the INIT sweep gives it a defined value instead.
    always_ff @(posedge clk) begin
        if (wr_en) ctr_q[wr_idx] <= wr_data;
    end

`ifdef PHT_BYPASS_EN
    assign lookup_ctr = (upd_commit && (upd_idx == lookup_idx)) ? upd_ctr_next : ctr_q[lookup_idx];
`else
    assign lookup_ctr = ctr_q[lookup_idx];
`endif

    always_comb begin
        pred_valid_d = lookup_req;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        if (lookup_req) begin
            pred_idx_d   = lookup_idx;
            pred_taken_d = (state_q == READY) & lookup_ctr[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_idx   = pred_idx_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed self-checking bench for gshare_pht; expectations follow the bypass macro PHT_BYPASS_EN.
module tb_gshare_pht;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic [3:0]  bhr_in;
    logic        pred_valid;
    logic        pred_taken;
    logic [3:0]  pred_idx;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        bhr_load;
    logic        bhr_branch_val;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    gshare_pht dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_req     (lookup_req),
        .lookup_pc      (lookup_pc),
        .bhr_in         (bhr_in),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .bhr_load       (bhr_load),
        .bhr_branch_val (bhr_branch_val),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [3:0] bhr);
        lookup_req = 1'b1;
        lookup_pc  = pc;
        bhr_in     = bhr;
        tick();
        lookup_req = 1'b0;
    endtask

    task automatic update(input logic [3:0] idx, input logic taken);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        logic bypass_exp;
        int   waited;
`ifdef PHT_BYPASS_EN
        bypass_exp = 1'b1;
`else
        bypass_exp = 1'b0;
`endif
        rst = 1'b1; lookup_req = 1'b0; lookup_pc = '0; bhr_in = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        tick(); tick();
        check("rst_pred_valid", pred_valid, 0);
        check("rst_ready", ready, 0);
        check("rst_bhr_load", bhr_load, 0);

        // Init sweep with lookups held on; one retire update lands mid-sweep
        rst = 1'b0;
        lookup_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("init_taken_%0d", k), pred_taken, 0);
            check($sformatf("init_valid_%0d", k), pred_valid, 1);
            check($sformatf("init_ready_%0d", k), ready, (k == 16));
            if (k == 5) begin
                upd_valid = 1'b1; upd_idx = 4'd1; upd_taken = 1'b1;
                #1;
                check("init_bhr_load", bhr_load, 1);
                check("init_bhr_val", bhr_branch_val, 1);
            end else begin
                upd_valid = 1'b0;
            end
        end
        lookup_req = 1'b0;

        // Entry 1 must still be weakly not-taken
        lookup(32'h4, 4'h0);
        check("idx1_after_init", pred_taken, 0);
        update(4'd1, 1'b1);
        lookup(32'h4, 4'h0);
        check("idx1_one_taken", pred_taken, 1);

        // Two taken updates on idx 3
        update(4'd3, 1'b1);
        update(4'd3, 1'b1);
        lookup(32'hC, 4'h0);
        check("idx3_valid", pred_valid, 1);
        check("idx3_idx", pred_idx, 3);
        check("idx3_taken", pred_taken, 1);
        tick();
        check("idle_valid", pred_valid, 0);
        check("idle_idx_hold", pred_idx, 3);
        check("idle_taken_hold", pred_taken, 1);

        // Saturation on idx 5, reached through pc=0x4 ^ bhr=4
        for (int i = 0; i < 5; i++) update(4'd5, 1'b1);
        update(4'd5, 1'b0);
        lookup(32'h4, 4'h4);
        check("idx5_idx", pred_idx, 5);
        check("idx5_ctr10", pred_taken, 1);
        update(4'd5, 1'b0);
        update(4'd5, 1'b0);
        lookup(32'h4, 4'h4);
        check("idx5_ctr00", pred_taken, 0);
        update(4'd5, 1'b0);
        update(4'd5, 1'b1);
        lookup(32'h4, 4'h4);
        check("idx5_floor_then_inc", pred_taken, 0);
        update(4'd5, 1'b1);
        lookup(32'h4, 4'h4);
        check("idx5_ctr10_again", pred_taken, 1);

        // Same-cycle lookup and update on idx 6
        upd_valid = 1'b1; upd_idx = 4'd6; upd_taken = 1'b1;
        lookup(32'h18, 4'h0);
        upd_valid = 1'b0;
        check("idx6_same_cycle", pred_taken, bypass_exp);
        lookup(32'h18, 4'h0);
        check("idx6_later", pred_taken, 1);

        // Different indices in the same cycle stay independent
        upd_valid = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1;
        lookup(32'h20, 4'h0);
        upd_valid = 1'b0;
        check("idx8_indep", pred_taken, 0);
        lookup(32'h24, 4'h0);
        check("idx9_updated", pred_taken, 1);

        // Train idx 2 to strongly taken, then reset mid-operation
        update(4'd2, 1'b1);
        update(4'd2, 1'b1);
        lookup(32'h8, 4'h0);
        check("idx2_trained", pred_taken, 1);
        lookup_req = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", pred_valid, 0);
        check("midrst_taken", pred_taken, 0);
        check("midrst_idx", pred_idx, 0);
        check("midrst_ready", ready, 0);
        check("midrst_bhr_load", bhr_load, 0);
        check("midrst_bhr_val", bhr_branch_val, 0);
        upd_valid = 1'b0; lookup_req = 1'b0;
        tick();
        rst = 1'b0;
        waited = 0;
        while (!ready && waited < 40) begin
            tick();
            waited++;
        end
        check("resweep_done", ready, 1);
        check("resweep_cycles", waited, 16);
        lookup(32'h8, 4'h0);
        check("idx2_after_reset", pred_taken, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
